// File: rtl/ntt_fifo_pkg.sv
// Shared widths and the per-bank tag record for the NTT ping-pong FIFO.
package ntt_fifo_pkg;

    localparam int BIT_WIDTH     = 16;
    localparam int LINE_SIZE     = 4;
    localparam int DATA_WIDTH    = BIT_WIDTH * LINE_SIZE;
    localparam int ADDR_WIDTH    = 4;
    localparam int RLWE_ID_WIDTH = 4;
    localparam int POLY_ID_WIDTH = 4;
    localparam int OPCODE_WIDTH  = 4;

    // Tags travelling with one polynomial from producer to consumer
    typedef struct packed {
        logic [RLWE_ID_WIDTH-1:0] rlwe_id;
        logic [POLY_ID_WIDTH-1:0] poly_id;
        logic [OPCODE_WIDTH-1:0]  opcode;
    } tag_t;

endpackage

// File: rtl/tdp_line_ram.sv
// Dual-port line RAM: two write ports and two independent registered read ports.
// Port A takes priority over port B when both write the same address.
module tdp_line_ram
    import ntt_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = ntt_fifo_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = ntt_fifo_pkg::ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  we_a,
    input  logic [ADDR_WIDTH-1:0] wr_addr_a,
    input  logic [DATA_WIDTH-1:0] wr_data_a,
    input  logic                  we_b,
    input  logic [ADDR_WIDTH-1:0] wr_addr_b,
    input  logic [DATA_WIDTH-1:0] wr_data_b,
    input  logic [ADDR_WIDTH-1:0] rd_addr_a,
    input  logic [ADDR_WIDTH-1:0] rd_addr_b,
    output logic [DATA_WIDTH-1:0] rd_data_a,
    output logic [DATA_WIDTH-1:0] rd_data_b
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_a_d, rd_a_q, rd_b_d, rd_b_q;

    // Storage array: B is written first so A overrides it on an address clash
    always_ff @(posedge clk) begin
        if (we_b) mem[wr_addr_b] <= wr_data_b;
        if (we_a) mem[wr_addr_a] <= wr_data_a;
    end

    // Combinational array lookup feeding the read registers
    always_comb begin
        rd_a_d = mem[rd_addr_a];
        rd_b_d = mem[rd_addr_b];
    end

    // Read registers give exactly one cycle of latency and clear on reset
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_a_q <= '0;
            rd_b_q <= '0;
        end else begin
            rd_a_q <= rd_a_d;
            rd_b_q <= rd_b_d;
        end
    end

    assign rd_data_a = rd_a_q;
    assign rd_data_b = rd_b_q;

endmodule

// File: rtl/ntt_pingpong_fifo.sv
// Ping-pong polynomial buffer between a producer and an NTT consumer.
// The producer fills one bank while the consumer drains the other; ownership
// moves on wr_finish / rd_finish pulses.
module ntt_pingpong_fifo
    import ntt_fifo_pkg::*;
#(
    parameter int DATA_WIDTH    = ntt_fifo_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH    = ntt_fifo_pkg::ADDR_WIDTH,
    parameter int RLWE_ID_WIDTH = ntt_fifo_pkg::RLWE_ID_WIDTH,
    parameter int POLY_ID_WIDTH = ntt_fifo_pkg::POLY_ID_WIDTH,
    parameter int OPCODE_WIDTH  = ntt_fifo_pkg::OPCODE_WIDTH
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [ADDR_WIDTH-1:0]    src_addrA,
    input  logic [ADDR_WIDTH-1:0]    src_addrB,
    input  logic [DATA_WIDTH-1:0]    src_dA,
    input  logic [DATA_WIDTH-1:0]    src_dB,
    input  logic                     src_weA,
    input  logic                     src_weB,
    input  logic                     src_wr_finish,
    input  logic [RLWE_ID_WIDTH-1:0] src_rlwe_id,
    input  logic [POLY_ID_WIDTH-1:0] src_poly_id,
    input  logic [OPCODE_WIDTH-1:0]  src_opcode,
    output logic                     src_full,
    input  logic [ADDR_WIDTH-1:0]    snk_addrA,
    input  logic [ADDR_WIDTH-1:0]    snk_addrB,
    output logic [DATA_WIDTH-1:0]    snk_dA,
    output logic [DATA_WIDTH-1:0]    snk_dB,
    input  logic                     snk_rd_finish,
    output logic                     snk_empty,
    output logic [RLWE_ID_WIDTH-1:0] snk_rlwe_id,
    output logic [POLY_ID_WIDTH-1:0] snk_poly_id,
    output logic [OPCODE_WIDTH-1:0]  snk_opcode
);

    logic       wr_sel_q, wr_sel_d;
    logic       rd_sel_q, rd_sel_d;
    logic       rd_sel_dly_q;
    logic [1:0] cnt_q, cnt_d;
    logic       full_q, empty_q;
    tag_t       tag_q [2];
    tag_t       tag_d [2];
    tag_t       tag_in, tag_cur;
    logic       wr_acc, rd_acc;

    logic                  ping_we_a, ping_we_b, pong_we_a, pong_we_b;
    logic [DATA_WIDTH-1:0] ping_qa, ping_qb, pong_qa, pong_qb;

    assign tag_in  = '{rlwe_id: src_rlwe_id, poly_id: src_poly_id, opcode: src_opcode};
    assign wr_acc  = src_wr_finish && !full_q;
    assign rd_acc  = snk_rd_finish && !empty_q;

    // Bank ownership, fill count and tag capture for the next cycle
    always_comb begin
        wr_sel_d = wr_sel_q;
        rd_sel_d = rd_sel_q;
        cnt_d    = cnt_q;
        tag_d    = tag_q;
        if (wr_acc) begin
            tag_d[wr_sel_q] = tag_in;
            wr_sel_d        = ~wr_sel_q;
        end
        if (rd_acc) begin
            rd_sel_d = ~rd_sel_q;
        end
        case ({wr_acc, rd_acc})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Control state; flags are registered from the next-state count
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_sel_q     <= 1'b0;
            rd_sel_q     <= 1'b0;
            rd_sel_dly_q <= 1'b0;
            cnt_q        <= 2'd0;
            full_q       <= 1'b0;
            empty_q      <= 1'b1;
            tag_q[0]     <= '0;
            tag_q[1]     <= '0;
        end else begin
            wr_sel_q     <= wr_sel_d;
            rd_sel_q     <= rd_sel_d;
            rd_sel_dly_q <= rd_sel_q;
            cnt_q        <= cnt_d;
            full_q       <= (cnt_d == 2'd2);
            empty_q      <= (cnt_d == 2'd0);
            tag_q        <= tag_d;
        end
    end

    // Writes go only to the bank the producer owns, and only while not full
    assign ping_we_a = src_weA && !full_q && !wr_sel_q;
    assign ping_we_b = src_weB && !full_q && !wr_sel_q;
    assign pong_we_a = src_weA && !full_q &&  wr_sel_q;
    assign pong_we_b = src_weB && !full_q &&  wr_sel_q;

    tdp_line_ram #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_ping (
        .clk       (clk),
        .rstn      (rstn),
        .we_a      (ping_we_a),
        .wr_addr_a (src_addrA),
        .wr_data_a (src_dA),
        .we_b      (ping_we_b),
        .wr_addr_b (src_addrB),
        .wr_data_b (src_dB),
        .rd_addr_a (snk_addrA),
        .rd_addr_b (snk_addrB),
        .rd_data_a (ping_qa),
        .rd_data_b (ping_qb)
    );

    tdp_line_ram #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_pong (
        .clk       (clk),
        .rstn      (rstn),
        .we_a      (pong_we_a),
        .wr_addr_a (src_addrA),
        .wr_data_a (src_dA),
        .we_b      (pong_we_b),
        .wr_addr_b (src_addrB),
        .wr_data_b (src_dB),
        .rd_addr_a (snk_addrA),
        .rd_addr_b (snk_addrB),
        .rd_data_a (pong_qa),
        .rd_data_b (pong_qb)
    );

    // Both banks are read every cycle; the select is delayed to line up with
    // the registered RAM output, so a read in the rd_finish cycle sees the old bank
    assign snk_dA = rd_sel_dly_q ? pong_qa : ping_qa;
    assign snk_dB = rd_sel_dly_q ? pong_qb : ping_qb;

    assign tag_cur     = tag_q[rd_sel_q];
    assign snk_rlwe_id = tag_cur.rlwe_id;
    assign snk_poly_id = tag_cur.poly_id;
    assign snk_opcode  = tag_cur.opcode;
    assign src_full    = full_q;
    assign snk_empty   = empty_q;

endmodule

// File: tb/tb_ntt_pingpong_fifo.sv
// Directed bench for ntt_pingpong_fifo with hand-computed expectations.
module tb_ntt_pingpong_fifo;
    import ntt_fifo_pkg::*;

    logic                     clk = 1'b0;
    logic                     rstn;
    logic [ADDR_WIDTH-1:0]    src_addrA, src_addrB, snk_addrA, snk_addrB;
    logic [DATA_WIDTH-1:0]    src_dA, src_dB, snk_dA, snk_dB;
    logic                     src_weA, src_weB, src_wr_finish, snk_rd_finish;
    logic [RLWE_ID_WIDTH-1:0] src_rlwe_id, snk_rlwe_id;
    logic [POLY_ID_WIDTH-1:0] src_poly_id, snk_poly_id;
    logic [OPCODE_WIDTH-1:0]  src_opcode, snk_opcode;
    logic                     src_full, snk_empty;

    int n_chk  = 0;
    int n_pass = 0;

    ntt_pingpong_fifo dut (
        .clk           (clk),
        .rstn          (rstn),
        .src_addrA     (src_addrA),
        .src_addrB     (src_addrB),
        .src_dA        (src_dA),
        .src_dB        (src_dB),
        .src_weA       (src_weA),
        .src_weB       (src_weB),
        .src_wr_finish (src_wr_finish),
        .src_rlwe_id   (src_rlwe_id),
        .src_poly_id   (src_poly_id),
        .src_opcode    (src_opcode),
        .src_full      (src_full),
        .snk_addrA     (snk_addrA),
        .snk_addrB     (snk_addrB),
        .snk_dA        (snk_dA),
        .snk_dB        (snk_dB),
        .snk_rd_finish (snk_rd_finish),
        .snk_empty     (snk_empty),
        .snk_rlwe_id   (snk_rlwe_id),
        .snk_poly_id   (snk_poly_id),
        .snk_opcode    (snk_opcode)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        src_addrA = '0; src_addrB = '0; src_dA = '0; src_dB = '0;
        src_weA = 1'b0; src_weB = 1'b0; src_wr_finish = 1'b0;
        src_rlwe_id = '0; src_poly_id = '0; src_opcode = '0;
        snk_addrA = '0; snk_addrB = '0; snk_rd_finish = 1'b0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        idle_inputs();
        tick();
        tick();
        rstn = 1'b1;
        tick();
    endtask

    task automatic wr_line(input int aa, input logic [63:0] da, input logic wa,
                           input int ab, input logic [63:0] db, input logic wb);
        src_addrA = ADDR_WIDTH'(aa); src_dA = da; src_weA = wa;
        src_addrB = ADDR_WIDTH'(ab); src_dB = db; src_weB = wb;
        tick();
        src_weA = 1'b0; src_weB = 1'b0;
    endtask

    task automatic pulse(input logic wf, input logic rf, input int r, input int p, input int o);
        src_rlwe_id = RLWE_ID_WIDTH'(r);
        src_poly_id = POLY_ID_WIDTH'(p);
        src_opcode  = OPCODE_WIDTH'(o);
        src_wr_finish = wf;
        snk_rd_finish = rf;
        tick();
        src_wr_finish = 1'b0;
        snk_rd_finish = 1'b0;
    endtask

    task automatic rd(input int aa, input int ab);
        snk_addrA = ADDR_WIDTH'(aa);
        snk_addrB = ADDR_WIDTH'(ab);
        tick();
    endtask

    initial begin
        rstn = 1'b0;
        idle_inputs();
        tick();
        tick();
        // reset state, sampled while reset is held
        check("rst_empty", 64'(snk_empty), 64'd1);
        check("rst_full",  64'(src_full),  64'd0);
        check("rst_dA",    snk_dA, 64'd0);
        check("rst_dB",    snk_dB, 64'd0);
        check("rst_rlwe",  64'(snk_rlwe_id), 64'd0);
        rstn = 1'b1;
        tick();

        // test 1: one polynomial, A low half, B high half
        for (int i = 0; i < 8; i++)
            wr_line(i, 64'(3 * i), 1'b1, i + 8, 64'(3 * (i + 8) + 1), 1'b1);
        check("t1_empty_pre", 64'(snk_empty), 64'd1);
        pulse(1'b1, 1'b0, 1, 2, 3);
        check("t1_empty", 64'(snk_empty), 64'd0);
        check("t1_full",  64'(src_full),  64'd0);
        check("t1_rlwe",  64'(snk_rlwe_id), 64'd1);
        check("t1_poly",  64'(snk_poly_id), 64'd2);
        check("t1_op",    64'(snk_opcode),  64'd3);
        rd(5, 12);
        check("t1_dA5",  snk_dA, 64'd15);
        check("t1_dB12", snk_dB, 64'd37);

        // test 2: both banks full, writes and commits dropped
        do_reset();
        wr_line(0, 64'h50, 1'b1, 0, 64'h0, 1'b0);
        pulse(1'b1, 1'b0, 1, 0, 0);
        wr_line(0, 64'h60, 1'b1, 0, 64'h0, 1'b0);
        pulse(1'b1, 1'b0, 2, 0, 0);
        check("t2_full", 64'(src_full), 64'd1);
        wr_line(0, 64'hAA, 1'b1, 0, 64'hAA, 1'b1);
        pulse(1'b1, 1'b0, 3, 0, 0);
        check("t2_full_hold", 64'(src_full), 64'd1);
        check("t2_rlwe_hold", 64'(snk_rlwe_id), 64'd1);
        rd(0, 0);
        check("t2_bank0", snk_dA, 64'h50);
        pulse(1'b0, 1'b1, 0, 0, 0);
        check("t2_full_drop", 64'(src_full), 64'd0);
        check("t2_rlwe2", 64'(snk_rlwe_id), 64'd2);
        rd(0, 0);
        check("t2_bank1", snk_dA, 64'h60);

        // test 3: simultaneous commit and release with one bank filled
        pulse(1'b1, 1'b1, 4, 5, 6);
        check("t3_full",  64'(src_full),  64'd0);
        check("t3_empty", 64'(snk_empty), 64'd0);
        check("t3_rlwe",  64'(snk_rlwe_id), 64'd4);
        check("t3_poly",  64'(snk_poly_id), 64'd5);
        check("t3_op",    64'(snk_opcode),  64'd6);
        rd(0, 0);
        check("t3_drop_kept", snk_dA, 64'h50);

        // test 4: release while empty, commit while full
        pulse(1'b0, 1'b1, 0, 0, 0);
        check("t4_empty", 64'(snk_empty), 64'd1);
        pulse(1'b0, 1'b1, 0, 0, 0);
        check("t4_empty_hold", 64'(snk_empty), 64'd1);
        check("t4_full_hold",  64'(src_full),  64'd0);
        wr_line(3, 64'h33, 1'b1, 0, 64'h0, 1'b0);
        pulse(1'b1, 1'b0, 7, 0, 0);
        check("t4_rlwe7", 64'(snk_rlwe_id), 64'd7);
        rd(3, 3);
        check("t4_d3", snk_dA, 64'h33);
        pulse(1'b1, 1'b0, 8, 0, 0);
        check("t4_full", 64'(src_full), 64'd1);
        pulse(1'b1, 1'b0, 9, 0, 0);
        check("t4_full_ign", 64'(src_full), 64'd1);
        check("t4_rlwe_ign", 64'(snk_rlwe_id), 64'd7);
        pulse(1'b0, 1'b1, 0, 0, 0);
        check("t4_rlwe8", 64'(snk_rlwe_id), 64'd8);

        // test 5: asynchronous reset in the middle of filling the second bank
        do_reset();
        wr_line(1, 64'h41, 1'b1, 0, 64'h0, 1'b0);
        pulse(1'b1, 1'b0, 1, 1, 1);
        rd(1, 1);
        check("t5_pre_dA", snk_dA, 64'h41);
        src_addrA = 4'd2; src_dA = 64'h77; src_weA = 1'b1;
        #2 rstn = 1'b0;
        #1;
        check("t5_empty", 64'(snk_empty), 64'd1);
        check("t5_full",  64'(src_full),  64'd0);
        check("t5_dA",    snk_dA, 64'd0);
        check("t5_rlwe",  64'(snk_rlwe_id), 64'd0);
        idle_inputs();
        tick();
        rstn = 1'b1;
        tick();
        wr_line(9, 64'h99, 1'b1, 0, 64'h0, 1'b0);
        pulse(1'b1, 1'b0, 5, 0, 0);
        check("t5_rlwe5", 64'(snk_rlwe_id), 64'd5);
        rd(9, 1);
        check("t5_bank0", snk_dA, 64'h99);
        check("t5_bank0_old", snk_dB, 64'h41);

        // test 6: same-address dual write, port A wins
        wr_line(7, 64'h11, 1'b1, 7, 64'h22, 1'b1);
        pulse(1'b1, 1'b0, 6, 0, 0);
        pulse(1'b0, 1'b1, 0, 0, 0);
        check("t6_rlwe6", 64'(snk_rlwe_id), 64'd6);
        rd(7, 7);
        check("t6_same_addr", snk_dA, 64'h11);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ntt_pingpong_fifo.md
Name: ntt_pingpong_fifo

Overview:
- Double-buffered (ping-pong) polynomial FIFO between a producer stage (source port) and an NTT consumer stage (sink port).
- Each bank holds one full polynomial of LINE_SIZE-coefficient lines, plus its RLWE/poly/opcode tags.
- The producer fills one bank while the consumer drains the other. Bank ownership transfers on wr_finish and rd_finish pulses.

Parameters:
- DATA_WIDTH, `BIT_WIDTH*`LINE_SIZE, width of one buffer line.
- ADDR_WIDTH, `ADDR_WIDTH, line address width; DEPTH = 2**ADDR_WIDTH lines per bank.
- RLWE_ID_WIDTH, `RLWE_ID_WIDTH, RLWE tag width.
- POLY_ID_WIDTH, `POLY_ID_WIDTH, poly tag width.
- OPCODE_WIDTH, `OPCODE_WIDTH, opcode width.

Ports:
- clk  in  1  single clock.
- rstn  in  1  reset, asynchronous, active-low.
- src_addrA, src_addrB  in  ADDR_WIDTH  write addresses, ports A/B.
- src_dA, src_dB  in  DATA_WIDTH  write data.
- src_weA, src_weB  in  1  write enables.
- src_wr_finish  in  1  one-cycle pulse: write bank complete.
- src_rlwe_id, src_poly_id, src_opcode  in  tag widths  tags, sampled on src_wr_finish.
- src_full  out  1  no free bank for writing.
- snk_addrA, snk_addrB  in  ADDR_WIDTH  read addresses.
- snk_dA, snk_dB  out  DATA_WIDTH  read data.
- snk_rd_finish  in  1  one-cycle pulse: read bank consumed.
- snk_empty  out  1  no filled bank available.
- snk_rlwe_id, snk_poly_id, snk_opcode  out  tag widths  tags of the current read bank.

Behaviour:
- State registers:
  - wr_sel: bank being written.
  - rd_sel: bank being read.
  - cnt: filled banks, range 0..2.
  - tag_reg[2]: per-bank tags.
- Reset (async on rstn low):
  - wr_sel=0, rd_sel=0, cnt=0.
  - src_full=0, snk_empty=1.
  - snk_dA/snk_dB=0; tag outputs=0.
  - RAM contents are not cleared.
- Flags, registered from next-state cnt, so they change the cycle after the pulse edge:
  - src_full = (cnt==2).
  - snk_empty = (cnt==0).
- Write path:
  - If src_weX && !src_full, write src_dX to bank[wr_sel][src_addrX].
  - Writes while src_full=1 are dropped.
  - If addrA==addrB with both we set, port A wins.
- Write commit: src_wr_finish && !src_full:
  - tag_reg[wr_sel] <= src tags.
  - wr_sel toggles.
  - cnt += 1.
  - src_wr_finish while full is ignored.
- Read path:
  - snk_dX <= bank[rd_sel][snk_addrX] every cycle.
  - Read latency is exactly 1 cycle.
  - Reads while empty return stale data; this is not an error.
- Tag outputs:
  - Combinational from tag_reg[rd_sel].
  - Valid whenever snk_empty=0.
- Read release: snk_rd_finish && !snk_empty:
  - rd_sel toggles.
  - cnt -= 1.
  - snk_rd_finish while empty is ignored.
- Simultaneous accepted wr_finish and rd_finish in the same cycle:
  - cnt unchanged.
  - Both selectors toggle.
  - Legal with cnt=1 only when the banks differ. With cnt=1, wr_sel != rd_sel by construction.
- Pulses held high for more than one cycle count once per cycle. The producer and consumer must pulse.
- Read-during-commit: the read data registered in the same cycle as rd_finish still comes from the old bank.
- Reset mid-operation: all bank ownership is discarded; partially written data becomes unreachable until rewritten.

Decomposition:
- Package ntt_fifo_pkg holds:
  - Width localparams derived from common.vh (DATA_WIDTH, tag widths).
  - A packed struct tag_t {rlwe_id, poly_id, opcode}.
- Sub-module tdp_line_ram: true dual-port, 1-cycle registered read, DEPTH x DATA_WIDTH.
  - Instantiated twice (ping, pong).
  - The write/read bank mux lives in the top.

Test Plan:
1. Reset, then idle: snk_empty=1, src_full=0, snk_dA=0. Write 16 lines (data = addr*3 on A, addr*3+1 on B) with tags (rlwe 1, poly 2, op 3), then wr_finish -> next cycle snk_empty=0, tags=1/2/3. Read addr 5 -> snk_dA=15 one cycle later.
2. Fill both banks with tags (1,0,0) and (2,0,0) -> src_full=1. Further write to addr 0 with data 0xAA is dropped; extra wr_finish is ignored. Drain the first bank -> tags switch to rlwe 2, src_full=0.
3. cnt=1: simultaneous wr_finish and rd_finish -> src_full and snk_empty unchanged (0/0). Tags show the newly committed polynomial.
4. rd_finish while empty, and wr_finish while full -> cnt, selectors and flags unchanged.
5. Assert rstn low asynchronously, mid-write of the second bank with cnt=1 -> outputs return to reset values without waiting for a clk edge. Post-reset the first write lands in bank 0.
6. Same-address dual write (addr 7, A=0x11, B=0x22) -> read addr 7 returns 0x11.
